// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg: shared front-end sizing constants and instruction type for the fetch/decode queue.
package inst_queue_pkg;
   localparam int INST_W     = 32;
   localparam int FETCH_W    = 8;
   localparam int ISSUE_W    = 4;
   localparam int IBUF_DEPTH = 32;
   typedef logic [INST_W-1:0] inst_t;
   localparam inst_t NOP = 32'h0000_0013;
endpackage

// File: rtl/inst_queue_if.sv
// inst_queue_if: fetch-side and decode-side signals of the instruction queue.
interface inst_queue_if #(
   parameter int DATA_W = 32,
   parameter int IN_W   = 8,
   parameter int OUT_W  = 4,
   parameter int DEPTH  = 32
);
   logic                         flush_i;
   logic [IN_W-1:0]              in_vld_i;
   logic [IN_W*DATA_W-1:0]       in_inst_i;
   logic                         in_rdy_o;
   logic [OUT_W-1:0]             out_vld_o;
   logic [OUT_W*DATA_W-1:0]      out_inst_o;
   logic [$clog2(OUT_W+1)-1:0]   deq_cnt_i;
   logic [$clog2(DEPTH+1)-1:0]   count_o;
   logic                         full_o;
   logic                         empty_o;
   modport master (
      output flush_i, in_vld_i, in_inst_i, deq_cnt_i,
      input  in_rdy_o, out_vld_o, out_inst_o, count_o, full_o, empty_o
   );
   modport slave (
      input  flush_i, in_vld_i, in_inst_i, deq_cnt_i,
      output in_rdy_o, out_vld_o, out_inst_o, count_o, full_o, empty_o
   );
endinterface

// File: rtl/inst_queue_compact.sv
// inst_compact: packs valid fetch slots in slot order using a prefix sum of the valid bits.
module inst_compact
   import inst_queue_pkg::*;
#(
   parameter int DATA_W = INST_W,
   parameter int IN_W   = FETCH_W,
   localparam int NW    = $clog2(IN_W+1)
) (
   input  logic [IN_W-1:0]        vld_i,
   input  logic [IN_W*DATA_W-1:0] inst_i,
   output logic [IN_W*DATA_W-1:0] packed_o,
   output logic [NW-1:0]          cnt_o
);
   logic [NW-1:0] off [IN_W];
   for (genvar k = 0; k < IN_W; k++) begin : g_off
      assign off[k] = NW'($countones(vld_i & IN_W'((64'd1 << k) - 64'd1)));
   end
   assign cnt_o = NW'($countones(vld_i));
   always_comb begin
      packed_o = '0;
      for (int j = 0; j < IN_W; j++)
         for (int k = 0; k < IN_W; k++)
            if (vld_i[k] && off[k] == NW'(j)) packed_o[j*DATA_W +: DATA_W] = inst_i[k*DATA_W +: DATA_W];
   end
endmodule

// File: rtl/inst_queue.sv
// inst_queue: circular fetch-to-decode buffer with bundle compaction, variable dequeue and flush.
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int DATA_W = INST_W,
   parameter int IN_W   = FETCH_W,
   parameter int OUT_W  = ISSUE_W,
   parameter int DEPTH  = IBUF_DEPTH
) (
   input logic        clock,
   input logic        reset,
   inst_queue_if.slave q
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int DW = $clog2(OUT_W+1);
   localparam int NW = $clog2(IN_W+1);
   logic [PW-1:0]          rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [DATA_W-1:0]      mem_q [DEPTH];
   logic [IN_W*DATA_W-1:0] packed_w;
   logic [NW-1:0]          n;
   logic [DW-1:0]          avail, deq_eff;
   logic [CW-1:0]          free_w;
   inst_compact #(.DATA_W(DATA_W), .IN_W(IN_W)) u_compact (
      .vld_i    (q.in_vld_i),
      .inst_i   (q.in_inst_i),
      .packed_o (packed_w),
      .cnt_o    (n)
   );
   assign free_w     = CW'(DEPTH) - cnt_q;
   assign q.in_rdy_o = !reset && !q.flush_i && free_w >= CW'(IN_W);
   assign q.count_o  = cnt_q;
   assign q.empty_o  = cnt_q == '0;
   assign q.full_o   = free_w < CW'(IN_W);
   assign avail      = cnt_q > CW'(OUT_W) ? DW'(OUT_W) : DW'(cnt_q);
   assign deq_eff    = q.deq_cnt_i > avail ? avail : q.deq_cnt_i;
   always_comb begin
      rd_d  = q.flush_i ? '0 : rd_q + PW'(deq_eff);
      wr_d  = q.flush_i ? '0 : wr_q + (q.in_rdy_o ? PW'(n) : '0);
      cnt_d = q.flush_i ? '0 : cnt_q + (q.in_rdy_o ? CW'(n) : '0) - CW'(deq_eff);
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end
   // storage is deliberately not reset; out_vld masks stale entries
   always_ff @(posedge clock) begin
      for (int j = 0; j < IN_W; j++)
         if (q.in_rdy_o && NW'(j) < n) mem_q[wr_q + PW'(j)] <= packed_w[j*DATA_W +: DATA_W];
   end
   for (genvar k = 0; k < OUT_W; k++) begin : g_out
      assign q.out_vld_o[k]                   = cnt_q > CW'(k);
      assign q.out_inst_o[k*DATA_W +: DATA_W] = q.out_vld_o[k] ? mem_q[rd_q + PW'(k)] : '0;
   end
   always_ff @(posedge clock) begin
      if (!reset && !q.flush_i) assert (q.deq_cnt_i <= avail);
   end
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed vectors with hand-computed expectations for inst_queue.
module tb_inst_queue;
   logic clk = 0;
   logic rst = 1;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   inst_queue_if #(.DATA_W(32), .IN_W(8), .OUT_W(4), .DEPTH(32)) qi ();
   inst_queue dut (.clock(clk), .reset(rst), .q(qi.slave));
   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic [7:0] v, input logic [31:0] base, input logic [2:0] d, input logic f);
      qi.in_vld_i  = v;
      qi.deq_cnt_i = d;
      qi.flush_i   = f;
      for (int k = 0; k < 8; k++) qi.in_inst_i[k*32 +: 32] = base + 32'(k);
   endtask
   initial begin
      drive(8'h00, 32'h0, 3'd0, 1'b0);
      cyc();
      cyc();
      chk("rst_rdy", 128'(qi.in_rdy_o), 128'd0);
      chk("rst_cnt", 128'(qi.count_o), 128'd0);
      chk("rst_empty", 128'(qi.empty_o), 128'd1);
      chk("rst_full", 128'(qi.full_o), 128'd0);
      chk("rst_vld", 128'(qi.out_vld_o), 128'd0);
      chk("rst_out", qi.out_inst_o, 128'd0);
      rst = 0;
      // 1: full bundle
      drive(8'hFF, 32'h100, 3'd0, 1'b0);
      #1 chk("t1_rdy", 128'(qi.in_rdy_o), 128'd1);
      cyc();
      drive(8'h00, 32'h0, 3'd0, 1'b0);
      chk("t1_cnt", 128'(qi.count_o), 128'd8);
      chk("t1_vld", 128'(qi.out_vld_o), 128'hF);
      chk("t1_out", qi.out_inst_o, {32'h103, 32'h102, 32'h101, 32'h100});
      drive(8'h00, 32'h0, 3'd0, 1'b1);
      cyc();
      drive(8'h00, 32'h0, 3'd0, 1'b0);
      chk("t1_flush_empty", 128'(qi.empty_o), 128'd1);
      // 2: holes in bundle
      drive(8'b1010_0101, 32'hA0, 3'd0, 1'b0);
      cyc();
      drive(8'h00, 32'h0, 3'd0, 1'b0);
      chk("t2_cnt", 128'(qi.count_o), 128'd4);
      chk("t2_vld", 128'(qi.out_vld_o), 128'hF);
      chk("t2_out", qi.out_inst_o, {32'hA7, 32'hA5, 32'hA2, 32'hA0});
      // 3: fill to 25 and back-pressure
      drive(8'hFF, 32'h200, 3'd0, 1'b0); cyc();
      drive(8'hFF, 32'h300, 3'd0, 1'b0); cyc();
      chk("t3_cnt20", 128'(qi.count_o), 128'd20);
      chk("t3_rdy20", 128'(qi.in_rdy_o), 128'd1);
      drive(8'h1F, 32'h400, 3'd0, 1'b0); cyc();
      drive(8'hFF, 32'h500, 3'd0, 1'b0);
      #1 chk("t3_cnt25", 128'(qi.count_o), 128'd25);
      chk("t3_full", 128'(qi.full_o), 128'd1);
      chk("t3_rdy0", 128'(qi.in_rdy_o), 128'd0);
      cyc();
      chk("t3_hold", 128'(qi.count_o), 128'd25);
      chk("t3_head", qi.out_inst_o, {32'hA7, 32'hA5, 32'hA2, 32'hA0});
      drive(8'hFF, 32'h500, 3'd4, 1'b0);
      #1 chk("t3_rdy_deq", 128'(qi.in_rdy_o), 128'd0);
      cyc();
      drive(8'h00, 32'h0, 3'd0, 1'b0);
      #1 chk("t3_cnt21", 128'(qi.count_o), 128'd21);
      chk("t3_rdy_back", 128'(qi.in_rdy_o), 128'd1);
      chk("t3_notfull", 128'(qi.full_o), 128'd0);
      chk("t3_out", qi.out_inst_o, {32'h203, 32'h202, 32'h201, 32'h200});
      // 4: move both pointers to 28, then enqueue across the wrap
      drive(8'h00, 32'h0, 3'd0, 1'b1); cyc();
      drive(8'hFF, 32'h0, 3'd0, 1'b0); cyc(); cyc(); cyc();
      drive(8'h0F, 32'h0, 3'd0, 1'b0); cyc();
      chk("t4_cnt28", 128'(qi.count_o), 128'd28);
      drive(8'h00, 32'h0, 3'd4, 1'b0);
      for (int i = 0; i < 7; i++) cyc();
      drive(8'h00, 32'h0, 3'd0, 1'b0);
      chk("t4_empty", 128'(qi.empty_o), 128'd1);
      drive(8'hFF, 32'h500, 3'd0, 1'b0); cyc();
      drive(8'h00, 32'h0, 3'd0, 1'b0);
      chk("t4_cnt8", 128'(qi.count_o), 128'd8);
      chk("t4_out_hi", qi.out_inst_o, {32'h503, 32'h502, 32'h501, 32'h500});
      drive(8'h00, 32'h0, 3'd4, 1'b0); cyc();
      drive(8'h00, 32'h0, 3'd0, 1'b0);
      chk("t4_out_lo", qi.out_inst_o, {32'h507, 32'h506, 32'h505, 32'h504});
      chk("t4_cnt4", 128'(qi.count_o), 128'd4);
      // 5: simultaneous dequeue and enqueue
      drive(8'h00, 32'h0, 3'd1, 1'b0); cyc();
      drive(8'h00, 32'h0, 3'd0, 1'b0);
      chk("t5_cnt3", 128'(qi.count_o), 128'd3);
      chk("t5_vld3", 128'(qi.out_vld_o), 128'h7);
      chk("t5_out3", qi.out_inst_o, {32'h0, 32'h507, 32'h506, 32'h505});
      drive(8'hFF, 32'h600, 3'd3, 1'b0); cyc();
      drive(8'h00, 32'h0, 3'd0, 1'b0);
      chk("t5_cnt8", 128'(qi.count_o), 128'd8);
      chk("t5_out", qi.out_inst_o, {32'h603, 32'h602, 32'h601, 32'h600});
      // 6: flush wins over enqueue and dequeue
      drive(8'h0F, 32'h700, 3'd0, 1'b0); cyc();
      chk("t6_cnt12", 128'(qi.count_o), 128'd12);
      drive(8'hFF, 32'h900, 3'd4, 1'b1);
      #1 chk("t6_rdy_flush", 128'(qi.in_rdy_o), 128'd0);
      cyc();
      drive(8'h00, 32'h0, 3'd0, 1'b0);
      chk("t6_cnt0", 128'(qi.count_o), 128'd0);
      chk("t6_empty", 128'(qi.empty_o), 128'd1);
      chk("t6_vld0", 128'(qi.out_vld_o), 128'd0);
      chk("t6_out0", qi.out_inst_o, 128'd0);
      drive(8'b0100_0000, 32'h800, 3'd0, 1'b0); cyc();
      drive(8'h00, 32'h0, 3'd0, 1'b0);
      chk("t6_cnt1", 128'(qi.count_o), 128'd1);
      chk("t6_vld1", 128'(qi.out_vld_o), 128'h1);
      chk("t6_out1", qi.out_inst_o, {96'h0, 32'h806});
      // reset mid-operation, with a flush also requested
      drive(8'hFF, 32'hB00, 3'd0, 1'b0); cyc();
      chk("rst2_pre", 128'(qi.count_o), 128'd9);
      rst = 1;
      drive(8'hFF, 32'hC00, 3'd0, 1'b1);
      #1 chk("rst2_rdy", 128'(qi.in_rdy_o), 128'd0);
      cyc();
      chk("rst2_cnt", 128'(qi.count_o), 128'd0);
      chk("rst2_vld", 128'(qi.out_vld_o), 128'd0);
      rst = 0;
      drive(8'h00, 32'h0, 3'd0, 1'b0); cyc();
      chk("rst2_hold", 128'(qi.count_o), 128'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
